// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_PUSH_HI,
    S_PUSH_LO,
    S_JUMP
  } pipe_state_e;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_VEC = 2'b10;
  localparam logic [1:0] PC_RST = 2'b11;

  localparam logic PUSH_PC_HI = 1'b0;
  localparam logic PUSH_PC_LO = 1'b1;

endpackage

// File: rtl/pipe_ctrl_int_edge_latch.sv
// Interrupt rising-edge detector with a single pending flag; further edges
// merge into the outstanding request until it is cleared.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic clr,
  output logic pending
);

  logic int_q;
  logic rise;

  assign rise = int_req & ~int_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      int_q <= int_req;
      // clear wins so an edge during vector entry is absorbed by this request
      if (clr)
        pending <= 1'b0;
      else if (rise)
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: enacts load-use stalls, taken-branch
// redirects and the interrupt drain/push/vector sequence.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_stall,
  input  logic        branch_taken,
  input  logic        int_req,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_push,
  output logic        push_sel,
  output logic        int_ack,
  output pipe_state_e state_dbg
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  pipe_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pending;
  logic             pend_clr;

  int_edge_latch u_int_edge_latch (
    .clk     (clk),
    .rst     (rst),
    .int_req (int_req),
    .clr     (pend_clr),
    .pending (pending)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pend_clr    = 1'b0;
    pc_en       = 1'b1;
    pc_sel      = PC_INC;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_push    = 1'b0;
    push_sel    = PUSH_PC_HI;
    int_ack     = 1'b0;

    if (rst) begin
      // outputs held at the reset-vector fetch with the pipe flushed
      pc_sel      = PC_RST;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state)
        S_RUN: begin
          if (branch_taken) begin
            pc_sel      = PC_BR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (pending) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            cnt_next    = DRAIN_LOAD;
            state_next  = S_DRAIN;
          end
        end

        S_DRAIN: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          // an older branch still in execute must redirect so the pushed PC is right
          if (branch_taken) begin
            pc_en       = 1'b1;
            pc_sel      = PC_BR;
            id_ex_flush = 1'b1;
          end
          if (cnt == '0)
            state_next = S_PUSH_HI;
          else
            cnt_next = cnt - 1'b1;
        end

        S_PUSH_HI: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          mem_push    = 1'b1;
          push_sel    = PUSH_PC_HI;
          state_next  = S_PUSH_LO;
        end

        S_PUSH_LO: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          mem_push    = 1'b1;
          push_sel    = PUSH_PC_LO;
          state_next  = S_JUMP;
        end

        S_JUMP: begin
          pc_sel      = PC_VEC;
          if_id_flush = 1'b1;
          int_ack     = 1'b1;
          pend_clr    = 1'b1;
          state_next  = S_RUN;
        end

        default: state_next = S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-index model of the
// interrupt entry sequence and the RUN-state priority rules.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst, lus, br, ir;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, mem_push, push_sel, int_ack;
  logic [1:0]  pc_sel;
  pipe_state_e state_dbg;
  logic [8:0]  obs;

  int checks   = 0;
  int failures = 0;

  // model: m_seq = -1 when running, else cycles since interrupt acceptance
  int m_seq  = -1;
  bit m_pend = 1'b0;
  bit m_prev = 1'b0;

  pipe_ctrl #(.DRAIN_CYCLES(D), .CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_stall (lus),
    .branch_taken   (br),
    .int_req        (ir),
    .pc_en          (pc_en),
    .pc_sel         (pc_sel),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .mem_push       (mem_push),
    .push_sel       (push_sel),
    .int_ack        (int_ack),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, mem_push, push_sel, int_ack};

  // expected {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_flush, mem_push, push_sel, int_ack}
  function automatic logic [8:0] exp_vec();
    if (rst)              return 9'b1_11_0_1_1_000;
    if (m_seq < 0) begin
      if (br)             return 9'b1_01_1_1_1_000;
      if (lus)            return 9'b0_00_0_0_1_000;
      if (m_pend)         return 9'b0_00_1_1_0_000;
      return 9'b1_00_1_0_0_000;
    end
    if (m_seq <= D)       return br ? 9'b1_01_1_1_1_000 : 9'b0_00_1_1_0_000;
    if (m_seq == D + 1)   return 9'b0_00_1_1_0_100;
    if (m_seq == D + 2)   return 9'b0_00_1_1_0_110;
    return 9'b1_10_1_1_0_001;
  endfunction

  // advance one clock edge and move the model with the inputs of this cycle
  task automatic tick();
    int ns;
    bit np, pv;
    if (rst) begin
      ns = -1; np = 1'b0; pv = 1'b0;
    end else begin
      if (m_seq < 0)          ns = (!br && !lus && m_pend) ? 1 : -1;
      else if (m_seq < D + 3) ns = m_seq + 1;
      else                    ns = -1;
      np = (m_seq == D + 3) ? 1'b0 : (m_pend | (ir & ~m_prev));
      pv = ir;
    end
    @(posedge clk);
    m_seq = ns; m_pend = np; m_prev = pv;
    #1;
  endtask

  task automatic drive(input logic l, input logic b, input logic i);
    lus = l; br = b; ir = i;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk); checks++;
      if (obs !== exp_vec()) begin $display("FAIL reset_pre c=%0d got=%b exp=%b", c, obs, exp_vec()); failures++; end
      tick();
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); checks++;
      if (obs !== 9'b1_11_0_1_1_000) begin $display("FAIL reset_hold c=%0d got=%b exp=%b", c, obs, 9'b1_11_0_1_1_000); failures++; end
      tick();
    end
    rst = 1'b0;
    @(negedge clk); checks++;
    if (pc_en !== 1'b1 || pc_sel !== PC_INC || state_dbg !== S_RUN) begin
      $display("FAIL reset_release got pc_en=%b pc_sel=%b state=%0d exp 1 00 RUN", pc_en, pc_sel, state_dbg);
      failures++;
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if ({pc_en, if_id_en, id_ex_flush} !== 3'b001 || obs !== exp_vec()) begin
      $display("FAIL load_use_stall got=%b exp=%b", obs, exp_vec()); failures++;
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk); checks++;
    if (obs !== 9'b1_00_1_0_0_000) begin $display("FAIL load_use_after got=%b exp=%b", obs, 9'b1_00_1_0_0_000); failures++; end
    tick();
  endtask

  task automatic test_branch_over_stall();
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk); checks++;
    if (obs !== 9'b1_01_1_1_1_000 || obs !== exp_vec()) begin
      $display("FAIL branch_over_stall got=%b exp=%b", obs, 9'b1_01_1_1_1_000); failures++;
    end
    tick();
  endtask

  task automatic test_interrupt(input int br_cyc, input string tag);
    int hi_c, lo_c, ack_c, acks;
    hi_c = -1; lo_c = -1; ack_c = -1; acks = 0;
    for (int c = 0; c < 18; c++) begin
      drive(1'b0, (c == br_cyc), 1'b1);
      @(negedge clk); checks++;
      if (obs !== exp_vec()) begin $display("FAIL %s_cyc c=%0d got=%b exp=%b", tag, c, obs, exp_vec()); failures++; end
      if (mem_push && push_sel == PUSH_PC_HI) hi_c = c;
      if (mem_push && push_sel == PUSH_PC_LO) lo_c = c;
      if (int_ack) begin acks++; ack_c = c; end
      if (c == br_cyc) begin
        checks++;
        if (pc_en !== 1'b1 || pc_sel !== PC_BR || id_ex_flush !== 1'b1) begin
          $display("FAIL %s_drain_branch got pc_en=%b pc_sel=%b id_ex_flush=%b exp 1 01 1", tag, pc_en, pc_sel, id_ex_flush);
          failures++;
        end
      end
      tick();
    end
    checks++;
    if (hi_c != 5 || lo_c != 6 || ack_c != 7 || acks != 1) begin
      $display("FAIL %s_timing got hi=%0d lo=%0d ack=%0d acks=%0d exp 5 6 7 1", tag, hi_c, lo_c, ack_c, acks);
      failures++;
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_in_push();
    int acks, ack_c;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b1);
      tick();
    end
    checks++;
    if (mem_push !== 1'b1 || push_sel !== PUSH_PC_HI) begin $display("FAIL push_hi_reached got mem_push=%b push_sel=%b exp 1 0", mem_push, push_sel); failures++; end
    rst = 1'b1; ir = 1'b0;
    #1; checks++;
    if (mem_push !== 1'b0) begin $display("FAIL push_abort got mem_push=%b exp 0", mem_push); failures++; end
    tick();
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (int_ack) acks++;
      tick();
    end
    checks++;
    if (acks != 0) begin $display("FAIL no_ack_after_abort got acks=%0d exp 0", acks); failures++; end
    ack_c = -1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b1);
      @(negedge clk); checks++;
      if (obs !== exp_vec()) begin $display("FAIL restart c=%0d got=%b exp=%b", c, obs, exp_vec()); failures++; end
      if (int_ack && ack_c < 0) ack_c = c;
      tick();
    end
    checks++;
    if (ack_c != 7) begin $display("FAIL restart_ack got cyc=%0d exp 7", ack_c); failures++; end
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      lus = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) ir = ~ir;
      rst = ($urandom_range(0, 59) == 0);
      @(negedge clk); checks++;
      if (obs !== exp_vec()) begin
        $display("FAIL random c=%0d rst=%b lus=%b br=%b ir=%b got=%b exp=%b", c, rst, lus, br, ir, obs, exp_vec());
        failures++;
      end
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_load_use();
    test_branch_over_stall();
    for (int c = 0; c < 3; c++) begin drive(1'b0, 1'b0, 1'b0); tick(); end
    test_interrupt(-1, "int_entry");
    test_interrupt(3, "int_drain_br");
    test_reset_in_push();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It consumes hazard and redirect requests (load-use stall from the decode-stage hazard detector, taken branch from execute, external interrupt) and drives the PC enable, the IF/ID enable, the per-stage flush strobes, the PC source select and the interrupt-entry push sequence. The hazard detector raises requests; this block enacts them on the pipeline registers and PC.

## Interface
- DRAIN_CYCLES, 3: bubbles inserted after interrupt acceptance before the PC is pushed (≥1).
- CNT_W, 2: drain counter width; must hold DRAIN_CYCLES-1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- load_use_stall  in  1  high = load-use hazard on the instruction in decode.
- branch_taken  in  1  high = branch/jump resolved taken in execute this cycle.
- int_req  in  1  external interrupt line, level; acted on at its rising edge.
- pc_en  out  1  PC register load enable.
- pc_sel  out  2  PC source: 00 PC+1, 01 branch target, 10 interrupt vector, 11 reset vector.
- if_id_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP into ID/EX.
- mem_push  out  1  request a stack write in the memory stage this cycle.
- push_sel  out  1  push data: 0 PC[31:16], 1 PC[15:0].
- int_ack  out  1  one-cycle pulse when the vector is loaded.

## Operation
- States: RUN, DRAIN, PUSH_HI, PUSH_LO, JUMP. Reset → RUN.
- Edge detector: int_q registers int_req; rising edge (int_req & ~int_q) sets pending. pending clears only in JUMP; edges while pending or outside RUN merge into the current request (no queue).
- RUN, priority highest first:
  - branch_taken: pc_en=1, pc_sel=01, if_id_flush=1, id_ex_flush=1 (load_use_stall ignored, its instruction is squashed).
  - load_use_stall: pc_en=0, if_id_en=0, id_ex_flush=1, pc_sel=00.
  - pending: pc_en=0, if_id_flush=1; counter←DRAIN_CYCLES-1; → DRAIN.
  - else: pc_en=1, if_id_en=1, pc_sel=00, no flushes.
- DRAIN: pc_en=0, if_id_flush=1. If branch_taken: pc_en=1, pc_sel=01, id_ex_flush=1 (PC then holds the correct return address). Counter decrements; at 0 → PUSH_HI. load_use_stall ignored (decode holds bubbles).
- PUSH_HI: mem_push=1, push_sel=0, pc_en=0, if_id_flush=1 → PUSH_LO.
- PUSH_LO: mem_push=1, push_sel=1, pc_en=0, if_id_flush=1 → JUMP.
- JUMP: pc_en=1, pc_sel=10, int_ack=1, if_id_flush=1, pending←0 → RUN.
- Defaults in every state unless stated: if_id_en=1, flushes 0, mem_push 0, int_ack 0, pc_sel 00.

## Timing
- Outputs are combinational from state and inputs; state, counter, pending and int_q are registered.
- While rst high: pc_en=1, pc_sel=11, if_id_en=0, if_id_flush=1, id_ex_flush=1, mem_push=0, push_sel=0, int_ack=0; state RUN, pending=0, int_q=0, counter=0.
- Load-use: one stall cycle per asserted cycle; the request drops once the bubble reaches execute.
- Interrupt latency, edge to int_ack: 1 (edge→pending) + 1 (accept) + DRAIN_CYCLES + 2 push cycles; = 7 cycles at default when RUN is unblocked.
- Reset mid-sequence aborts it: no further pushes, pending lost.
- branch_taken and a pending edge in the same RUN cycle: branch serviced, interrupt accepted the next unblocked cycle.

## Structure
- pipe_ctrl_pkg: state enum, pc_sel codes (PC_INC, PC_BR, PC_VEC, PC_RST), push_sel codes.
- One sub-module: int_edge_latch (int_q, rising-edge detect, pending set/clear).

## Test plan
- Reset pulse mid-stream → all outputs at reset values during rst; first cycle after release pc_en=1, pc_sel=00, state RUN.
- load_use_stall high 1 cycle in RUN → that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal.
- load_use_stall and branch_taken same cycle → pc_sel=01, pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1.
- int_req rises at cycle 0 (defaults) → DRAIN cycles 2–4, mem_push push_sel=0 cycle 5, push_sel=1 cycle 6, int_ack with pc_sel=10 cycle 7; int_req held high → no second entry.
- branch_taken during DRAIN → that cycle pc_en=1, pc_sel=01, id_ex_flush=1; sequence still reaches int_ack at cycle 7.
- rst asserted in PUSH_HI → mem_push drops immediately, no int_ack; new int_req edge after release → full sequence restarts.
